// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 8 data bits, odd parity, stop, ACK.
// Both PS/2 lines are driven open-drain via active-high pull-low enables.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 10000,
   parameter int unsigned TIMEOUT_CYCLES = 2000000,
   parameter int unsigned FILTER_LEN     = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int unsigned InhW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
   localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYCLES - 1);
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle,
      StInhibit,
      StRts,
      StXfer,
      StAck,
      StWaitIdle
   } state_e;

   // Glitch filters: one sync flop, then a FILTER_LEN-deep all-equal window.
   logic                  clk_sync_q, data_sync_q;
   logic [FILTER_LEN-1:0] clk_sr_q, data_sr_q;
   logic                  clk_filt_q, clk_filt_d;
   logic                  data_filt_q, data_filt_d;
   logic                  fall_evt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync_q  <= 1'b1;
         data_sync_q <= 1'b1;
         clk_sr_q    <= '1;
         data_sr_q   <= '1;
         clk_filt_q  <= 1'b1;
         data_filt_q <= 1'b1;
      end else begin
         clk_sync_q  <= ps2_clk;
         data_sync_q <= ps2_data;
         clk_sr_q    <= {clk_sr_q[FILTER_LEN-2:0], clk_sync_q};
         data_sr_q   <= {data_sr_q[FILTER_LEN-2:0], data_sync_q};
         clk_filt_q  <= clk_filt_d;
         data_filt_q <= data_filt_d;
      end
   end

   always_comb begin
      clk_filt_d  = clk_filt_q;
      data_filt_d = data_filt_q;
      if (&clk_sr_q) begin
         clk_filt_d = 1'b1;
      end else if (~|clk_sr_q) begin
         clk_filt_d = 1'b0;
      end
      if (&data_sr_q) begin
         data_filt_d = 1'b1;
      end else if (~|data_sr_q) begin
         data_filt_d = 1'b0;
      end
   end

   assign fall_evt = clk_filt_q & ~clk_filt_d;

   state_e          state_q, state_d;
   logic [InhW-1:0] inh_q, inh_d;
   logic [TmoW-1:0] tmo_q, tmo_d;
   logic [3:0]      bitcnt_q, bitcnt_d;
   logic [7:0]      shreg_q, shreg_d;
   logic            parity_q, parity_d;
   logic            data_oe_q, data_oe_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic [3:0]      next_bit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         inh_q     <= '0;
         tmo_q     <= '0;
         bitcnt_q  <= '0;
         shreg_q   <= '0;
         parity_q  <= 1'b0;
         data_oe_q <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         inh_q     <= inh_d;
         tmo_q     <= tmo_d;
         bitcnt_q  <= bitcnt_d;
         shreg_q   <= shreg_d;
         parity_q  <= parity_d;
         data_oe_q <= data_oe_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      inh_d     = inh_q;
      tmo_d     = tmo_q;
      bitcnt_d  = bitcnt_q;
      shreg_d   = shreg_q;
      parity_d  = parity_q;
      data_oe_d = data_oe_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      next_bit  = bitcnt_q + 4'd1;

      unique case (state_q)
         StIdle: begin
            inh_d     = '0;
            tmo_d     = '0;
            data_oe_d = 1'b0;
            if (tx_valid) begin
               shreg_d  = tx_data;
               parity_d = ~^tx_data;
               state_d  = StInhibit;
            end
         end
         StInhibit: begin
            if (inh_q == InhLast) begin
               state_d = StRts;
            end else begin
               inh_d = inh_q + InhW'(1);
            end
         end
         StRts: begin
            bitcnt_d  = '0;
            data_oe_d = 1'b1;
            state_d   = StXfer;
         end
         StXfer: begin
            if (fall_evt) begin
               bitcnt_d = next_bit;
               // Fall n (1..8) presents data bit n-1, i.e. index bitcnt_q.
               if (next_bit <= 4'd8) begin
                  data_oe_d = ~shreg_q[bitcnt_q[2:0]];
               end else if (next_bit == 4'd9) begin
                  data_oe_d = ~parity_q;
               end else begin
                  data_oe_d = 1'b0;
                  state_d   = StAck;
               end
            end
         end
         StAck: begin
            if (fall_evt) begin
               if (data_filt_q) begin
                  err_d   = 1'b1;
                  state_d = StIdle;
               end else begin
                  state_d = StWaitIdle;
               end
            end
         end
         StWaitIdle: begin
            if (clk_filt_q && data_filt_q) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // Timeout overrides every other outcome once the device owns the clock.
      if (state_q inside {StRts, StXfer, StAck, StWaitIdle}) begin
         if (tmo_q == TmoLast) begin
            state_d   = StIdle;
            data_oe_d = 1'b0;
            done_d    = 1'b0;
            err_d     = 1'b1;
         end else begin
            tmo_d = tmo_q + TmoW'(1);
         end
      end
   end

   assign tx_ready    = (state_q == StIdle);
   assign busy        = (state_q != StIdle);
   assign ps2_clk_oe  = (state_q == StInhibit);
   assign ps2_data_oe = (state_q == StRts) | ((state_q == StXfer) & data_oe_q);
   assign done        = done_q;
   assign err         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a behavioural PS/2 device, queue-based scoreboard
// checking done/err pulses and the frame the device received.
module tb_ps2_host_tx;

   localparam int unsigned InhibitCycles = 32;
   localparam int unsigned TimeoutCycles = 4000;
   localparam int unsigned FilterLen     = 8;

   localparam int ModeNormal = 0;
   localparam int ModeSilent = 1;
   localparam int ModeNack   = 2;

   localparam int KindDone = 0;
   localparam int KindErr  = 1;
   localparam int KindNone = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       ps2_clk, ps2_data;
   logic       ps2_clk_oe, ps2_data_oe;
   logic       busy, done, err;

   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;

   // Wired-AND open-drain bus with pull-ups
   assign ps2_clk  = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_data = ~(ps2_data_oe | dev_data_low);

   ps2_host_tx #(
      .INHIBIT_CYCLES(InhibitCycles),
      .TIMEOUT_CYCLES(TimeoutCycles),
      .FILTER_LEN    (FilterLen)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_data_oe(ps2_data_oe),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        is_err;
      logic [10:0] frame;
   } exp_t;

   exp_t        exp_q[$];
   logic [10:0] rx_q[$];
   exp_t        mon_e;
   int          n_vec = 0;
   int          n_miss = 0;
   int          rx_frames = 0;
   int          dev_mode = ModeNormal;
   int          dev_bit = 0;
   logic        dev_active = 1'b0;
   logic        dev_abort = 1'b0;
   logic        glitch_en = 1'b0;
   logic [10:0] dev_frame;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_idle(input string name, input int limit);
      int n = 0;
      while ((busy || dev_active) && n < limit) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(n < limit), 32'd1);
   endtask

   // Frame as the device samples it: {stop, parity, d7..d0, start}
   task automatic send(input logic [7:0] b, input int kind, input logic par);
      exp_t e;
      @(negedge clk);
      wait_idle("pre_send_idle", 3000);
      if (kind != KindNone) begin
         e.is_err = (kind == KindErr);
         e.frame  = {1'b1, par, b, 1'b0};
         exp_q.push_back(e);
      end
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   // Device model: 20 clk low / 20 clk high, samples data when releasing its clock.
   initial begin : device
      forever begin
         @(negedge clk);
         if (rst_n && ps2_clk && !ps2_data && !dev_active) begin
            dev_active = 1'b1;
            if (dev_mode == ModeSilent) begin
               while (!ps2_data) @(negedge clk);
            end else begin
               repeat (30) @(negedge clk);
               dev_frame[0] = ps2_data;
               for (int k = 1; k <= 10; k++) begin
                  dev_bit     = k;
                  dev_clk_low = 1'b1;
                  repeat (20) @(negedge clk);
                  dev_clk_low  = 1'b0;
                  dev_frame[k] = ps2_data;
                  for (int j = 0; j < 20; j++) begin
                     dev_clk_low = glitch_en && (j == 10);
                     @(negedge clk);
                  end
               end
               dev_data_low = (dev_mode == ModeNormal);
               repeat (15) @(negedge clk);
               dev_clk_low = 1'b1;
               repeat (20) @(negedge clk);
               dev_clk_low = 1'b0;
               repeat (5) @(negedge clk);
               if (!dev_abort && dev_mode == ModeNormal) begin
                  rx_q.push_back(dev_frame);
                  rx_frames++;
               end
               dev_data_low = 1'b0;
               repeat (30) @(negedge clk);
            end
            dev_bit    = 0;
            dev_active = 1'b0;
         end
      end
   end

   // Scoreboard monitor
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (rst_n && (done || err)) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_miss++;
               $display("FAIL unexpected_pulse: got done=%0b err=%0b, expected none at %0t",
                        done, err, $time);
            end else begin
               mon_e = exp_q.pop_front();
               check("done_pulse", 32'(done), 32'(!mon_e.is_err));
               check("err_pulse", 32'(err), 32'(mon_e.is_err));
               check("idle_on_pulse", {28'd0, tx_ready, ps2_clk_oe, ps2_data_oe, busy}, 32'h8);
               if (!mon_e.is_err) begin
                  if (rx_q.size() == 0) begin
                     n_vec++;
                     n_miss++;
                     $display("FAIL frame: got no frame, expected 0x%0h", mon_e.frame);
                  end else begin
                     check("frame", 32'(rx_q.pop_front()), 32'(mon_e.frame));
                  end
               end
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got no end of test, expected end within time limit");
      $fatal(1, "bench time limit expired");
   end

   initial begin : stimulus
      int n;
      int rx_before;

      repeat (4) @(negedge clk);
      check("reset_outputs", {26'd0, ps2_clk_oe, ps2_data_oe, done, err, busy, tx_ready},
            32'h1);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // 0xED: inhibit length, then RTS
      send(8'hED, KindDone, 1'b1);
      n = 0;
      while (ps2_clk_oe && n < 1000) begin
         n++;
         @(negedge clk);
      end
      check("inhibit_cycles", 32'(n), 32'd32);
      check("rts_data_oe", 32'(ps2_data_oe), 32'd1);
      check("rts_clk_oe", 32'(ps2_clk_oe), 32'd0);
      wait_idle("ed_idle", 3000);
      check("ed_ready", 32'(tx_ready), 32'd1);

      send(8'hFF, KindDone, 1'b1);
      wait_idle("ff_idle", 3000);
      send(8'h00, KindDone, 1'b1);
      wait_idle("00_idle", 3000);

      // Silent device: timeout
      dev_mode = ModeSilent;
      send(8'hA5, KindErr, 1'b1);
      n = 0;
      while (!ps2_data_oe && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("rts_reached", 32'(n < 100), 32'd1);
      n = 0;
      while (!err && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("timeout_cycles", 32'(n), 32'd4000);
      check("timeout_lines", {29'd0, ps2_clk_oe, ps2_data_oe, done}, 32'd0);
      wait_idle("timeout_idle", 3000);

      // NACK
      dev_mode = ModeNack;
      send(8'h3C, KindErr, 1'b1);
      wait_idle("nack_idle", 3000);
      check("nack_lines", {28'd0, ps2_clk_oe, ps2_data_oe, tx_ready, busy}, 32'h2);
      check("nack_bus", {30'd0, ps2_clk, ps2_data}, 32'h3);
      dev_mode = ModeNormal;

      // Reset during bit 4
      send(8'h30, KindNone, 1'b1);
      n = 0;
      while (dev_bit != 4 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("reach_bit4", 32'(n < 1000), 32'd1);
      repeat (12) @(negedge clk);
      check("pre_reset_state", {30'd0, busy, ps2_data_oe}, 32'h3);
      dev_abort = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", {29'd0, ps2_clk_oe, ps2_data_oe, busy}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      while (dev_active && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("abort_drain", 32'(n < 1000), 32'd1);
      dev_abort = 1'b0;
      send(8'h55, KindDone, 1'b1);
      wait_idle("55_idle", 3000);

      // Clock glitches plus an ignored tx_valid while busy
      glitch_en = 1'b1;
      rx_before = rx_frames;
      send(8'h07, KindDone, 1'b0);
      n = 0;
      while (dev_bit != 3 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("reach_bit3", 32'(n < 1000), 32'd1);
      tx_data  = 8'h11;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      wait_idle("07_idle", 3000);
      repeat (100) @(negedge clk);
      check("one_frame_only", 32'(rx_frames - rx_before), 32'd1);
      check("stays_idle", 32'(busy), 32'd0);
      glitch_en = 1'b0;

      repeat (20) @(negedge clk);
      check("exp_drained", 32'(exp_q.size()), 32'd0);
      check("rx_drained", 32'(rx_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
